// File: rtl/mem_arb_pkg.sv
// Shared definitions for the two-master RAM arbiter: port indices and the
// request record carried from a port's capture latch to the RAM mux.
package mem_arb_pkg;

    localparam int NUM_PORTS = 2;
    localparam int PORT_CPU  = 0;
    localparam int PORT_LDR  = 1;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wmask;
        logic        is_read;
    } mem_req_t;

endpackage

// File: rtl/mem_req_latch.sv
// Per-port request capture: presents either the held (lost) request or the live
// strobe, and holds a losing request until it is granted.
module mem_req_latch
    import mem_arb_pkg::*;
(
    input  logic        clk,
    input  logic        resetn,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [3:0]  wmask,
    input  logic        rstrb,
    input  logic        grant,
    input  logic        ret_busy,
    output logic        req,
    output mem_req_t    cur,
    output logic        rbusy,
    output logic        wbusy
);

    mem_req_t pend;
    logic     pend_vld;
    logic     live;

    // A strobe landing while this port is busy is dropped; write wins over read.
    assign live  = resetn && !rbusy && !wbusy && (rstrb || wmask != 4'd0);
    assign req   = pend_vld || live;
    assign wbusy = pend_vld && !pend.is_read;
    assign rbusy = (pend_vld && pend.is_read) || ret_busy;

    always_comb begin
        cur = '{addr: addr, wdata: wdata, wmask: wmask, is_read: (wmask == 4'd0)};
        if (pend_vld)
            cur = pend;
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            pend_vld <= 1'b0;
            pend     <= '0;
        end else if (req && !grant) begin
            pend_vld <= 1'b1;
            pend     <= cur;
        end else if (grant) begin
            pend_vld <= 1'b0;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one synchronous-read RAM between the CPU (port 0)
// and the loader (port 1); routes registered read data back to the issuer.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int RAM_WORDS = 3072,
    parameter int AW        = 30
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    input  logic [3:0]  m0_wmask,
    input  logic        m0_rstrb,
    output logic [31:0] m0_rdata,
    output logic        m0_rbusy,
    output logic        m0_wbusy,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    input  logic [3:0]  m1_wmask,
    input  logic        m1_rstrb,
    output logic [31:0] m1_rdata,
    output logic        m1_rbusy,
    output logic        m1_wbusy,
    output logic [31:0] ram_addr,
    output logic [31:0] ram_wdata,
    output logic [3:0]  ram_wmask,
    output logic        ram_rstrb,
    input  logic [31:0] ram_rdata,
    output logic        addr_err
);

    logic [NUM_PORTS-1:0][31:0] p_addr, p_wdata, rdata;
    logic [NUM_PORTS-1:0][3:0]  p_wmask;
    logic [NUM_PORTS-1:0]       p_rstrb, req, gnt, ret_busy, rbusy, wbusy;
    mem_req_t [NUM_PORTS-1:0]   cur;

    mem_req_t sel;
    logic     sel_vld, sel_port, in_range;
    logic     rr_last;
    logic     ret_vld, ret_port, ret_err;

    assign p_addr  = {m1_addr,  m0_addr};
    assign p_wdata = {m1_wdata, m0_wdata};
    assign p_wmask = {m1_wmask, m0_wmask};
    assign p_rstrb = {m1_rstrb, m0_rstrb};

    generate
        for (genvar i = 0; i < NUM_PORTS; i++) begin : g_port
            assign ret_busy[i] = ret_vld && (ret_port == 1'(i));
            mem_req_latch u_latch (
                .clk      (clk),
                .resetn   (resetn),
                .addr     (p_addr[i]),
                .wdata    (p_wdata[i]),
                .wmask    (p_wmask[i]),
                .rstrb    (p_rstrb[i]),
                .grant    (gnt[i]),
                .ret_busy (ret_busy[i]),
                .req      (req[i]),
                .cur      (cur[i]),
                .rbusy    (rbusy[i]),
                .wbusy    (wbusy[i])
            );
        end
    endgenerate

    assign m0_rbusy = rbusy[PORT_CPU];
    assign m1_rbusy = rbusy[PORT_LDR];
    assign m0_wbusy = wbusy[PORT_CPU];
    assign m1_wbusy = wbusy[PORT_LDR];
    assign m0_rdata = rdata[PORT_CPU];
    assign m1_rdata = rdata[PORT_LDR];

    // On a tie the port that did not win the last tie goes first.
    always_comb begin
        gnt      = '0;
        sel_vld  = resetn && (|req);
        sel_port = (req[0] && req[1]) ? ~rr_last : req[1];
        gnt[sel_port] = sel_vld;
        sel      = cur[sel_port];
    end

    assign in_range = sel.addr[AW+1:2] < AW'(RAM_WORDS);

    always_comb begin
        ram_addr  = '0;
        ram_wdata = '0;
        ram_wmask = '0;
        ram_rstrb = 1'b0;
        if (sel_vld) begin
            ram_addr  = sel.addr;
            ram_wdata = sel.wdata;
            if (in_range) begin
                ram_wmask = sel.is_read ? 4'd0 : sel.wmask;
                ram_rstrb = sel.is_read;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            rr_last  <= 1'b1;
            ret_vld  <= 1'b0;
            ret_port <= 1'b0;
            ret_err  <= 1'b0;
            addr_err <= 1'b0;
            rdata    <= '0;
        end else begin
            if (req[0] && req[1])
                rr_last <= sel_port;
            ret_vld  <= sel_vld && sel.is_read;
            ret_port <= sel_port;
            ret_err  <= !in_range;
            if (sel_vld && !in_range)
                addr_err <= 1'b1;
            // Out-of-range reads were never sent to the RAM, so they return zero.
            if (ret_vld)
                rdata[ret_port] <= ret_err ? 32'd0 : ram_rdata;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: transaction-level reference model checked every cycle,
// a table of uncontended accesses, hand-written corner sequences and random traffic.
module tb_mem_arbiter;

    localparam int RAM_WORDS = 3072;

    logic        clk = 1'b0, resetn = 1'b0;
    logic [31:0] m0_addr = '0, m0_wdata = '0, m1_addr = '0, m1_wdata = '0;
    logic [3:0]  m0_wmask = '0, m1_wmask = '0;
    logic        m0_rstrb = 1'b0, m1_rstrb = 1'b0;
    logic [31:0] m0_rdata, m1_rdata, ram_addr, ram_wdata;
    logic [31:0] ram_rdata = '0;
    logic        m0_rbusy, m0_wbusy, m1_rbusy, m1_wbusy, ram_rstrb, addr_err;
    logic [3:0]  ram_wmask;

    always #5 clk = ~clk;

    mem_arbiter #(.RAM_WORDS(RAM_WORDS), .AW(30)) dut (
        .clk(clk), .resetn(resetn),
        .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_wmask(m0_wmask), .m0_rstrb(m0_rstrb),
        .m0_rdata(m0_rdata), .m0_rbusy(m0_rbusy), .m0_wbusy(m0_wbusy),
        .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_wmask(m1_wmask), .m1_rstrb(m1_rstrb),
        .m1_rdata(m1_rdata), .m1_rbusy(m1_rbusy), .m1_wbusy(m1_wbusy),
        .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_wmask(ram_wmask),
        .ram_rstrb(ram_rstrb), .ram_rdata(ram_rdata), .addr_err(addr_err)
    );

    // Synchronous-read RAM attached to the arbiter.
    logic [31:0] mem [0:RAM_WORDS-1];
    always @(posedge clk) begin : ram_model
        int w;
        w = int'(ram_addr[31:2]);
        if (w < RAM_WORDS) begin
            if (ram_rstrb) ram_rdata <= mem[w];
            for (int b = 0; b < 4; b++)
                if (ram_wmask[b]) mem[w][8*b +: 8] <= ram_wdata[8*b +: 8];
        end
    end

    typedef struct { bit v; bit rd; logic [31:0] a; logic [31:0] d; logic [3:0] m; } txn_t;
    typedef struct { int p; bit rd; logic [31:0] a; logic [31:0] d; logic [3:0] m; logic [31:0] exp; } vec_t;

    // Reference model state: queued losers, tie history, one outstanding read.
    txn_t        pend [2];
    int          last_win = 1;
    bit          ret_v = 0;
    int          ret_p = 0;
    logic [31:0] ret_d = '0;
    logic [31:0] exp_rd [2] = '{32'd0, 32'd0};
    bit          exp_err = 0;
    bit          armed = 0;
    int          win = -1;
    logic [31:0] shadow [int];
    txn_t        nil;
    int          checks = 0, errors = 0;

    function automatic txn_t mk(bit v, bit rd, logic [31:0] a, logic [31:0] d, logic [3:0] m);
        txn_t t;
        t.v = v; t.rd = rd; t.a = a; t.d = d; t.m = m;
        return t;
    endfunction

    function automatic bit in_rng(logic [31:0] a);
        return int'(a[31:2]) < RAM_WORDS;
    endfunction

    function automatic bit busy(int p);
        return pend[p].v || (ret_v && ret_p == p);
    endfunction

    function automatic logic [31:0] rdata_of(int p);
        return (p == 0) ? m0_rdata : m1_rdata;
    endfunction

    function automatic txn_t rnd_txn(int p);
        txn_t t;
        t.v = 1; t.rd = 1'($urandom % 2); t.d = $urandom;
        t.m = 4'($urandom_range(1, 15));
        if ($urandom % 8 == 0)
            t.a = 32'(RAM_WORDS * 4) + ($urandom % 32'h10000);
        else
            t.a = {26'd0, 1'(p), 3'($urandom % 8), 2'($urandom % 4)};
        return t;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input int p, input txn_t t);
        logic [3:0] m;
        logic       s;
        m = (t.v && !t.rd) ? t.m : 4'd0;
        s = t.v && t.rd;
        if (p == 0) begin m0_addr = t.a; m0_wdata = t.d; m0_wmask = m; m0_rstrb = s; end
        else        begin m1_addr = t.a; m1_wdata = t.d; m1_wmask = m; m1_rstrb = s; end
    endtask

    // One clock cycle: drive, predict, compare at the falling edge, advance model.
    task automatic tick(input txn_t l0, input txn_t l1, input bit rst);
        txn_t        rq [2];
        logic [31:0] old;
        bit          ok;
        int          k;
        @(posedge clk); #1;
        resetn = !rst;
        drive(0, l0); drive(1, l1);
        rq[0] = pend[0].v ? pend[0] : l0;
        rq[1] = pend[1].v ? pend[1] : l1;
        win = -1;
        if (!rst) begin
            if (rq[0].v && rq[1].v) win = 1 - last_win;
            else if (rq[0].v)       win = 0;
            else if (rq[1].v)       win = 1;
        end
        @(negedge clk);
        ok = (win >= 0) && in_rng(rq[win].a);
        chk("ram_rstrb", 32'(ram_rstrb), 32'(ok && rq[win].rd));
        chk("ram_wmask", 32'(ram_wmask), (ok && !rq[win].rd) ? 32'(rq[win].m) : 32'd0);
        if (ok) chk("ram_addr", ram_addr, rq[win].a);
        if (ok && !rq[win].rd) chk("ram_wdata", ram_wdata, rq[win].d);
        if (armed) begin
            chk("m0_wbusy", 32'(m0_wbusy), 32'(pend[0].v && !pend[0].rd));
            chk("m1_wbusy", 32'(m1_wbusy), 32'(pend[1].v && !pend[1].rd));
            chk("m0_rbusy", 32'(m0_rbusy), 32'((pend[0].v && pend[0].rd) || (ret_v && ret_p == 0)));
            chk("m1_rbusy", 32'(m1_rbusy), 32'((pend[1].v && pend[1].rd) || (ret_v && ret_p == 1)));
            chk("m0_rdata", m0_rdata, exp_rd[0]);
            chk("m1_rdata", m1_rdata, exp_rd[1]);
            chk("addr_err", 32'(addr_err), 32'(exp_err));
        end
        if (rst) begin
            pend[0].v = 0; pend[1].v = 0; last_win = 1; ret_v = 0;
            exp_rd[0] = '0; exp_rd[1] = '0; exp_err = 0; armed = 1;
        end else begin
            if (ret_v) exp_rd[ret_p] = ret_d;
            ret_v = 0;
            if (win >= 0) begin
                k = int'(rq[win].a[31:2]);
                if (!in_rng(rq[win].a)) begin
                    exp_err = 1; ret_d = '0;
                end else if (rq[win].rd) begin
                    ret_d = shadow.exists(k) ? shadow[k] : 32'hx;
                end else begin
                    old = shadow.exists(k) ? shadow[k] : 32'h0;
                    for (int b = 0; b < 4; b++)
                        if (rq[win].m[b]) old[8*b +: 8] = rq[win].d[8*b +: 8];
                    shadow[k] = old;
                end
                ret_v = rq[win].rd; ret_p = win;
                pend[win].v = 0;
                if (rq[1-win].v) begin pend[1-win] = rq[1-win]; last_win = win; end
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(nil, nil, 0);
    endtask

    vec_t tbl [8];

    initial begin
        int n;
        txn_t a0, a1;
        nil = mk(0, 0, 0, 0, 0);
        pend[0] = nil; pend[1] = nil;
        tick(nil, nil, 1); tick(nil, nil, 1);
        idle(1);
        chk("reset_m0_rdata", m0_rdata, 32'd0);
        chk("reset_addr_err", 32'(addr_err), 32'd0);

        for (int i = 0; i < 16; i++) begin
            tick(mk(1, 0, 32'(i * 4), 32'h1000_0000 + 32'(i), 4'hF), nil, 0);
        end
        idle(1);

        tbl = '{
            '{0, 0, 32'h10,   32'hDEADBEEF, 4'hF,    32'h0},
            '{0, 1, 32'h10,   32'h0,        4'h0,    32'hDEADBEEF},
            '{1, 0, 32'h30,   32'h12345678, 4'hF,    32'h0},
            '{1, 0, 32'h30,   32'h00AB0000, 4'b0100, 32'h0},
            '{1, 1, 32'h30,   32'h0,        4'h0,    32'h12AB5678},
            '{0, 0, 32'h14,   32'hA5A5A5A5, 4'b0011, 32'h0},
            '{1, 1, 32'h14,   32'h0,        4'h0,    32'h1000A5A5},
            '{0, 1, 32'h2FFC, 32'h0,        4'h0,    32'hx}
        };
        // Last word of the RAM is in range; write it before the final table read.
        tick(mk(1, 0, 32'h2FFC, 32'hCAFEF00D, 4'hF), nil, 0);
        tbl[7].exp = 32'hCAFEF00D;
        foreach (tbl[i]) begin
            a0 = mk(1, tbl[i].rd, tbl[i].a, tbl[i].d, tbl[i].m);
            if (tbl[i].p == 0) tick(a0, nil, 0); else tick(nil, a0, 0);
            idle(2);
            if (tbl[i].rd) begin
                chk("tbl_rdata", rdata_of(tbl[i].p), tbl[i].exp);
                chk("tbl_rbusy", 32'(tbl[i].p == 0 ? m0_rbusy : m1_rbusy), 32'd0);
            end
        end

        tick(mk(1, 0, 32'h20, 32'h11111111, 4'hF), mk(1, 0, 32'h24, 32'h22222222, 4'hF), 0);
        chk("tie_first_addr", ram_addr, 32'h20);
        tick(nil, nil, 0);
        chk("tie_m1_wbusy", 32'(m1_wbusy), 32'd1);
        chk("tie_second_addr", ram_addr, 32'h24);
        tick(nil, nil, 0);
        chk("tie_m1_wbusy_clr", 32'(m1_wbusy), 32'd0);
        tick(mk(1, 1, 32'h20, 0, 0), nil, 0); idle(2);
        chk("tie_word0", m0_rdata, 32'h11111111);
        tick(nil, mk(1, 1, 32'h24, 0, 0), 0); idle(2);
        chk("tie_word1", m1_rdata, 32'h22222222);

        tick(mk(1, 1, 32'(4 * RAM_WORDS), 0, 0), nil, 0);
        chk("oor_no_rstrb", 32'(ram_rstrb), 32'd0);
        idle(2);
        chk("oor_rdata", m0_rdata, 32'd0);
        chk("oor_err", 32'(addr_err), 32'd1);
        idle(5);
        chk("oor_err_sticky", 32'(addr_err), 32'd1);

        tick(mk(1, 1, 32'h20, 0, 0), nil, 0);
        tick(nil, nil, 1);
        tick(nil, nil, 1);
        tick(nil, nil, 0);
        chk("rst_mid_rdata", m0_rdata, 32'd0);
        chk("rst_mid_rbusy", 32'(m0_rbusy), 32'd0);
        chk("rst_mid_err", 32'(addr_err), 32'd0);
        tick(mk(1, 0, 32'h28, 32'h33333333, 4'hF), mk(1, 0, 32'h2C, 32'h44444444, 4'hF), 0);
        chk("rst_tie_port0", ram_addr, 32'h28);
        idle(2);

        tick(nil, nil, 1); tick(nil, nil, 1);
        n = 0;
        for (int c = 0; c < 200 && n < 20; c++) begin
            a0 = busy(0) ? nil : mk(1, 1, 32'(4 * $urandom_range(0, 7)), 0, 0);
            a1 = busy(1) ? nil : mk(1, 1, 32'(4 * $urandom_range(8, 15)), 0, 0);
            tick(a0, a1, 0);
            if (win >= 0) begin
                chk("rr_order", 32'(ram_addr[5]), 32'(n % 2));
                n++;
            end
        end
        chk("rr_count", 32'(n), 32'd20);
        idle(2);

        for (int c = 0; c < 600; c++) begin
            a0 = (!busy(0) && $urandom % 3 == 0) ? rnd_txn(0) : nil;
            a1 = (!busy(1) && $urandom % 3 == 0) ? rnd_txn(1) : nil;
            tick(a0, a1, (c % 150 == 149));
        end
        idle(3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
